// File: rtl/truth_table_sweeper.sv
// Exhaustive stimulus generator and checker for an N_IN-input, 1-output
// combinational block. Walks stim through 0..2^N_IN-1 in ascending order,
// holds each vector for SETTLE+1 cycles and samples dut_y on the last cycle.
// Each sample is compared with the golden EXPECTED truth table. The block
// counts mismatches (saturating) and latches the first failing index.
module truth_table_sweeper #(
  parameter int                    N_IN     = 3,
  parameter int                    SETTLE   = 2,
  parameter logic [(1<<N_IN)-1:0]  EXPECTED = 8'b1110_1000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            loop_en,
  input  logic            dut_y,
  output logic [N_IN-1:0] stim,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic            first_err_valid,
  output logic [N_IN-1:0] first_err_idx,
  output logic            sample_valid,
  output logic [N_IN-1:0] sample_idx,
  output logic            sample_y
);

  // The settle counter only has to reach SETTLE-1.
  localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);
  localparam logic [N_IN-1:0]  LAST_IDX    = '1;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_SAMPLE = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  logic [1:0]       state;
  logic [CNT_W-1:0] settle_cnt;
  logic             mismatch;
  logic [N_IN:0]    err_next;

  // Compare the current sample with the golden bit and form the saturated count.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    mismatch = 1'b0;
    err_next = err_count;
    mismatch = (dut_y != EXPECTED[stim]);
    if (mismatch && (err_count != '1)) begin
      err_next = err_count + 1'b1;
    end
  end

  // Sweep sequencer: start, settle, sample, advance or finish.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments keep every register update tied to the same edge, independent of statement order.
    if (!rst_n) begin
      state           <= ST_IDLE;
      settle_cnt      <= '0;
      stim            <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
      err_count       <= '0;
      first_err_valid <= 1'b0;
      first_err_idx   <= '0;
      sample_valid    <= 1'b0;
      sample_idx      <= '0;
      sample_y        <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state           <= ST_SETTLE;
            stim            <= '0;
            settle_cnt      <= '0;
            busy            <= 1'b1;
            done            <= 1'b0;
            pass            <= 1'b0;
            err_count       <= '0;
            first_err_valid <= 1'b0;
            first_err_idx   <= '0;
          end
        end
        ST_SETTLE: begin
          settle_cnt <= settle_cnt + 1'b1;
          if (settle_cnt == SETTLE_LAST) begin
            state <= ST_SAMPLE;
          end
        end
        ST_SAMPLE: begin
          err_count <= err_next;
          if (mismatch && !first_err_valid) begin
            first_err_idx   <= stim;
            first_err_valid <= 1'b1;
          end
          sample_valid <= 1'b1;
          sample_idx   <= stim;
          sample_y     <= dut_y;
          settle_cnt   <= '0;
          if (stim != LAST_IDX) begin
            stim  <= stim + 1'b1;
            state <= ST_SETTLE;
          end else if (loop_en) begin
            // Continuous mode: wrap and keep accumulating across passes.
            stim  <= '0;
            state <= ST_SETTLE;
          end else begin
            // pass uses err_next so the final vector's mismatch is included.
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_next == '0);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench for truth_table_sweeper. Three instances cover the default
// configuration (majority / XOR / constant-1 DUTs), a 2-input SETTLE=1 build
// and a 1-input build used to exercise counter saturation.
module tb_truth_table_sweeper;

  logic clk;
  logic rst_n;

  // Instance A: defaults (N_IN=3, SETTLE=2, EXPECTED=8'hE8)
  logic       start_a, loop_a, y_a;
  logic [2:0] stim_a;
  logic       busy_a, done_a, pass_a;
  logic [3:0] err_a;
  logic       fev_a;
  logic [2:0] fei_a;
  logic       sv_a;
  logic [2:0] si_a;
  logic       sy_a;
  logic [1:0] sel_a;

  // Instance B: N_IN=2, SETTLE=1, EXPECTED=4'b0110, XOR DUT
  logic       start_b, loop_b, y_b;
  logic [1:0] stim_b;
  logic       busy_b, done_b, pass_b;
  logic [2:0] err_b;
  logic       fev_b;
  logic [1:0] fei_b;
  logic       sv_b;
  logic [1:0] si_b;
  logic       sy_b;

  // Instance C: N_IN=1, SETTLE=2, EXPECTED=2'b00, constant-1 DUT
  logic       start_c, loop_c, y_c;
  logic [0:0] stim_c;
  logic       busy_c, done_c, pass_c;
  logic [1:0] err_c;
  logic       fev_c;
  logic [0:0] fei_c;
  logic       sv_c;
  logic [0:0] si_c;
  logic       sy_c;

  int n_checks = 0;
  int n_fail   = 0;

  logic [2:0] idx_q[$];
  logic [1:0] stim_q_b[$];
  logic [7:0] y_bits;
  logic       log_en;

  truth_table_sweeper u_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .loop_en(loop_a), .dut_y(y_a),
    .stim(stim_a), .busy(busy_a), .done(done_a), .pass(pass_a),
    .err_count(err_a), .first_err_valid(fev_a), .first_err_idx(fei_a),
    .sample_valid(sv_a), .sample_idx(si_a), .sample_y(sy_a)
  );

  truth_table_sweeper #(.N_IN(2), .SETTLE(1), .EXPECTED(4'b0110)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .loop_en(loop_b), .dut_y(y_b),
    .stim(stim_b), .busy(busy_b), .done(done_b), .pass(pass_b),
    .err_count(err_b), .first_err_valid(fev_b), .first_err_idx(fei_b),
    .sample_valid(sv_b), .sample_idx(si_b), .sample_y(sy_b)
  );

  truth_table_sweeper #(.N_IN(1), .SETTLE(2), .EXPECTED(2'b00)) u_c (
    .clk(clk), .rst_n(rst_n), .start(start_c), .loop_en(loop_c), .dut_y(y_c),
    .stim(stim_c), .busy(busy_c), .done(done_c), .pass(pass_c),
    .err_count(err_c), .first_err_valid(fev_c), .first_err_idx(fei_c),
    .sample_valid(sv_c), .sample_idx(si_c), .sample_y(sy_c)
  );

  always #5 clk = ~clk;

  // DUT models driven by each sweeper's stim
  always_comb begin
    case (sel_a)
      2'd0:    y_a = (stim_a[0] & stim_a[1]) | (stim_a[0] & stim_a[2]) | (stim_a[1] & stim_a[2]);
      2'd1:    y_a = ^stim_a;
      default: y_a = 1'b1;
    endcase
  end
  assign y_b = ^stim_b;
  assign y_c = 1'b1;

  // Log instance A sample pulses
  always @(negedge clk) begin
    if (log_en && sv_a) begin
      idx_q.push_back(si_a);
      y_bits[si_a] = sy_a;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pulse start_a for one edge; returns at the negedge after the start edge.
  task automatic pulse_start_a();
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
  endtask

  // Count edges after the start edge until done_a rises (bounded).
  task automatic wait_done_a(output int edges);
    edges = 0;
    while (!done_a && edges < 200) begin
      @(negedge clk);
      edges++;
    end
  endtask

  initial begin
    int   edges;
    int   exp_b[8] = '{0, 0, 1, 1, 2, 2, 3, 3};
    logic seen_done;

    clk = 1'b0; rst_n = 1'b0; sel_a = 2'd0; log_en = 1'b0; y_bits = '0;
    start_a = 1'b0; loop_a = 1'b0;
    start_b = 1'b0; loop_b = 1'b0;
    start_c = 1'b0; loop_c = 1'b0;

    // Reset state: every output 0
    #3;
    check("reset_a", {stim_a, busy_a, done_a, pass_a, err_a, fev_a, fei_a, sv_a, si_a, sy_a}, 0);
    check("reset_b", {stim_b, busy_b, done_b, pass_b, err_b, fev_b, fei_b, sv_b, si_b, sy_b}, 0);
    check("reset_c", {stim_c, busy_c, done_c, pass_c, err_c, fev_c, fei_c, sv_c, si_c, sy_c}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // B: 2-input XOR, start held high while busy -> no restart, 8 cycles
    start_b = 1'b1;
    @(negedge clk);
    edges = 0;
    while (!done_b && edges < 50) begin
      stim_q_b.push_back(stim_b);
      @(negedge clk);
      edges++;
    end
    start_b = 1'b0;
    check("b_cycles", edges, 8);
    check("b_pass", pass_b, 1);
    check("b_err", err_b, 0);
    check("b_log_len", stim_q_b.size(), 8);
    for (int i = 0; i < 8; i++) begin
      if (i < stim_q_b.size()) check($sformatf("b_stim_%0d", i), stim_q_b[i], exp_b[i]);
    end
    @(negedge clk);
    check("b_held_done", {done_b, busy_b}, 2'b10);

    // C: saturation, 2 mismatches per 6-cycle pass, 2-bit counter
    loop_c = 1'b1;
    start_c = 1'b1;
    @(negedge clk);
    start_c = 1'b0;
    repeat (6) @(negedge clk);
    check("c_err_pass1", err_c, 2);
    repeat (6) @(negedge clk);
    check("c_err_pass2", err_c, 3);
    repeat (6) @(negedge clk);
    check("c_err_pass3", err_c, 3);
    check("c_loop_state", {busy_c, done_c}, 2'b10);
    loop_c = 1'b0;
    edges = 0;
    while (!done_c && edges < 50) begin
      @(negedge clk);
      edges++;
    end
    check("c_cycles", edges, 6);
    check("c_final", {pass_c, err_c, fev_c, fei_c}, {1'b0, 2'd3, 1'b1, 1'b0});

    // A1: majority DUT -> clean pass in 24 cycles, 8 ordered samples
    sel_a = 2'd0;
    idx_q.delete();
    y_bits = '0;
    log_en = 1'b1;
    pulse_start_a();
    check("a1_start", {busy_a, stim_a}, {1'b1, 3'd0});
    wait_done_a(edges);
    check("a1_cycles", edges, 24);
    check("a1_result", {pass_a, err_a, fev_a}, {1'b1, 4'd0, 1'b0});
    @(negedge clk);
    log_en = 1'b0;
    check("a1_samples", idx_q.size(), 8);
    for (int i = 0; i < 8; i++) begin
      if (i < idx_q.size()) check($sformatf("a1_idx_%0d", i), idx_q[i], i);
    end
    check("a1_sample_y", y_bits, 8'hE8);

    // A3: constant-1 DUT looping, 4 mismatches per pass
    sel_a = 2'd2;
    loop_a = 1'b1;
    pulse_start_a();
    check("a3_start_clears_done", {done_a, pass_a, busy_a}, 3'b001);
    seen_done = 1'b0;
    for (int i = 0; i < 72; i++) begin
      @(negedge clk);
      if (done_a) seen_done = 1'b1;
    end
    check("a3_err_3pass", err_a, 12);
    check("a3_no_done", {seen_done, busy_a}, 2'b01);
    loop_a = 1'b0;
    wait_done_a(edges);
    check("a3_cycles_after_drop", edges, 24);
    // 16 mismatches in total; the 4-bit counter saturates at 15
    check("a3_err_final", err_a, 15);
    check("a3_first", {pass_a, fev_a, fei_a}, {1'b0, 1'b1, 3'd0});

    // A2: XOR DUT (8'h96) vs 8'hE8 -> mismatches at 1..6
    sel_a = 2'd1;
    pulse_start_a();
    check("a2_start_clears", {done_a, pass_a, err_a, fev_a, fei_a}, 0);
    wait_done_a(edges);
    check("a2_cycles", edges, 24);
    check("a2_result", {pass_a, err_a, fev_a, fei_a}, {1'b0, 4'd6, 1'b1, 3'd1});

    // Reset mid-sweep at stim=4, then a fresh sweep
    pulse_start_a();
    edges = 0;
    while (stim_a != 3'd4 && edges < 100) begin
      @(negedge clk);
      edges++;
    end
    check("ar_pre_reset", {stim_a, err_a, fev_a, busy_a}, {3'd4, 4'd3, 1'b1, 1'b1});
    #1 rst_n = 1'b0;
    #1;
    check("ar_async_reset", {stim_a, busy_a, done_a, pass_a, err_a, fev_a, fei_a, sv_a, si_a, sy_a}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    pulse_start_a();
    check("ar_restart", {stim_a, err_a, fev_a, busy_a}, {3'd0, 4'd0, 1'b0, 1'b1});
    wait_done_a(edges);
    check("ar_result", {edges[7:0], pass_a, err_a, fei_a}, {8'd24, 1'b0, 4'd6, 3'd1});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
